// File: rtl/inv_sub_bytes_seq_if.sv
// inv_sub_bytes_seq_if
//   Stream handshake bundle for the sequential InvSubBytes block.
//   Input stream : in_valid, in_data[127:0], in_ready
//   Output stream: out_valid, out_data[127:0], out_ready
//   master : the environment (upstream producer and downstream consumer)
//   slave  : the InvSubBytes block
interface inv_sub_bytes_seq_if;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq
//   Sequential AES InvSubBytes. A 128-bit state is captured, then LANES bytes
//   per cycle are passed through LANES shared inverse S-box lookups until all
//   16 bytes are substituted. The result is held until the consumer takes it.
// Ports
//   clk    : rising-edge clock
//   n_rst  : asynchronous active-low reset
//   clear  : synchronous abort back to IDLE (working register kept)
//   busy   : high whenever the FSM is not in IDLE
//   bus    : stream interface (slave modport), byte i = bits [8i+7:8i]
// Parameter
//   LANES  : lookups per cycle, one of 1, 2, 4, 8, 16

// inv_sbox
//   Combinational AES inverse S-box lookup.
// Ports
//   a : input byte
//   y : inverse S-box of a
module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] TABLE = {
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign y = TABLE[a];
endmodule

// FSM states
//   state | meaning
//   IDLE  | waiting for in_valid, in_ready=1
//   SUBST | substituting chunk cnt (LANES bytes) each cycle
//   DONE  | result valid on out_data, waiting for out_ready
module inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  output logic                 busy,
  inv_sub_bytes_seq_if.slave   bus
);
  localparam int CHUNKS = 16 / LANES;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SUBST = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     cnt;
  logic [15:0][7:0]  work;
  logic [3:0]        base;
  logic              last_chunk;
  logic [3:0]        lane_idx [LANES];
  logic [7:0]        sbox_in  [LANES];
  logic [7:0]        sbox_out [LANES];

  // First byte of the chunk currently being substituted. With a single chunk
  // cnt never leaves 0, so the product stays in range.
  assign base       = 4'(int'(cnt) * LANES);
  assign last_chunk = (cnt == CW'(CHUNKS - 1));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l] = base + 4'(l);
    assign sbox_in[l]  = work[lane_idx[l]];
    inv_sbox u_sbox (
      .a (sbox_in[l]),
      .y (sbox_out[l])
    );
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; clear overrides every other input
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.in_valid)  state_nxt = SUBST;
        SUBST:   if (last_chunk)    state_nxt = DONE;
        DONE:    if (bus.out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    busy          = (state != IDLE);
    bus.out_data  = work;
  end

  // Working register and chunk counter
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      work <= '0;
      cnt  <= '0;
    end else if (clear) begin
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            work <= bus.in_data;
            cnt  <= '0;
          end
        end
        SUBST: begin
          for (int l = 0; l < LANES; l++) begin
            work[lane_idx[l]] <= sbox_out[l];
          end
          cnt <= last_chunk ? '0 : cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
module tb_inv_sub_bytes_seq;
  logic clk   = 1'b0;
  logic n_rst = 1'b1;
  logic clear;
  logic busy;

  inv_sub_bytes_seq_if mif ();

  inv_sub_bytes_seq #(.LANES(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .busy  (busy),
    .bus   (mif.slave)
  );

  always #5 clk = ~clk;

  int         n_checks   = 0;
  int         n_fail     = 0;
  bit         sweep_go   = 1'b0;
  int         sweep_done = 0;
  logic [7:0] inv_ref [256];

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic hi;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // Reference inverse S-box built from GF(2^8) inversion plus the forward affine map
  task automatic build_ref();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] x, b, s;
      x = 8'(a);
      b = 8'h00;
      if (x != 8'h00) begin
        for (int y = 1; y < 256; y++) begin
          if (gmul(x, 8'(y)) == 8'h01) b = 8'(y);
        end
      end
      s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
      inv_ref[s] = x;
    end
  endtask

  // Caller is at a negative edge; returns at the next negative edge after the handshake
  task automatic run_job(input logic [127:0] din, input logic [127:0] exp, input string tag);
    int lat;
    chk({tag, " in_ready idle"}, 128'(mif.in_ready), 128'd1);
    mif.in_valid  = 1'b1;
    mif.in_data   = din;
    mif.out_ready = 1'b1;
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    mif.in_data  = ~din;
    chk({tag, " busy after accept"}, 128'(busy), 128'd1);
    chk({tag, " in_ready after accept"}, 128'(mif.in_ready), 128'd0);
    lat = 0;
    while (mif.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 128'(lat), 128'd4);
    chk({tag, " out_data"}, mif.out_data, exp);
    @(posedge clk); #1;
    chk({tag, " out_valid after handshake"}, 128'(mif.out_valid), 128'd0);
    chk({tag, " in_ready after handshake"}, 128'(mif.in_ready), 128'd1);
    @(negedge clk);
  endtask

  initial begin
    int  lat;
    bit  saw;
    build_ref();
    vecs[0] = '{din: {16{8'h63}}, dout: 128'h0};
    vecs[1] = '{din: {{12{8'h63}}, 8'h52, 8'h16, 8'h7c, 8'h00},
                dout: {96'h0, 8'h48, 8'hff, 8'h01, 8'h52}};
    vecs[2] = '{din: 128'h0, dout: {16{8'h52}}};
    vecs[3] = '{din: {96'h0, 8'h53, 8'h10, 8'hff, 8'h01},
                dout: {{12{8'h52}}, 8'h50, 8'h7c, 8'h7d, 8'h09}};
    vecs[4] = '{din: 128'h0f0e0d0c0b0a09080706050403020100,
                dout: 128'hfbd7f3819ea340bf38a53630d56a0952};

    clear         = 1'b0;
    mif.in_valid  = 1'b0;
    mif.in_data   = '0;
    mif.out_ready = 1'b0;

    // Asynchronous reset before any clock edge
    #1 n_rst = 1'b0;
    #1;
    chk("reset in_ready", 128'(mif.in_ready), 128'd1);
    chk("reset out_valid", 128'(mif.out_valid), 128'd0);
    chk("reset busy", 128'(busy), 128'd0);
    chk("reset out_data", mif.out_data, 128'h0);

    // Release and accept on the very first rising edge
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_job(vecs[i].din, vecs[i].dout, $sformatf("vec%0d", i));
    end

    // Result held in DONE while out_ready stays low; in_valid pulses ignored
    mif.in_valid  = 1'b1;
    mif.in_data   = vecs[4].din;
    mif.out_ready = 1'b0;
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    lat = 0;
    while (mif.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hold latency", 128'(lat), 128'd4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      mif.in_valid = 1'b1;
      mif.in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(posedge clk); #1;
      chk($sformatf("hold out_valid c%0d", k), 128'(mif.out_valid), 128'd1);
      chk($sformatf("hold out_data c%0d", k), mif.out_data, vecs[4].dout);
      chk($sformatf("hold in_ready c%0d", k), 128'(mif.in_ready), 128'd0);
    end
    // Handshake edge must not also accept the in_valid that is presented
    @(negedge clk);
    mif.out_ready = 1'b1;
    mif.in_valid  = 1'b1;
    mif.in_data   = vecs[0].din;
    @(posedge clk); #1;
    chk("release out_valid", 128'(mif.out_valid), 128'd0);
    chk("release no accept", 128'(busy), 128'd0);
    @(negedge clk);
    mif.in_valid = 1'b0;

    // Reset two edges into SUBST discards the job
    mif.in_valid  = 1'b1;
    mif.in_data   = vecs[1].din;
    mif.out_ready = 1'b0;
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    chk("rst subst out_valid", 128'(mif.out_valid), 128'd0);
    chk("rst subst in_ready", 128'(mif.in_ready), 128'd1);
    chk("rst subst out_data", mif.out_data, 128'h0);
    chk("rst subst busy", 128'(busy), 128'd0);
    @(negedge clk);
    n_rst = 1'b1;
    mif.out_ready = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (mif.out_valid !== 1'b0 || busy !== 1'b0) saw = 1'b1;
    end
    chk("rst subst no stray out_valid", 128'(saw), 128'd0);
    @(negedge clk);

    // Reset while in DONE, then accept on the first edge after release
    mif.in_valid  = 1'b1;
    mif.in_data   = vecs[3].din;
    mif.out_ready = 1'b0;
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    lat = 0;
    while (mif.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rst done reached", 128'(mif.out_valid), 128'd1);
    #2 n_rst = 1'b0;
    #1;
    chk("rst done out_valid", 128'(mif.out_valid), 128'd0);
    chk("rst done out_data", mif.out_data, 128'h0);
    @(negedge clk);
    n_rst = 1'b1;
    run_job(vecs[2].din, vecs[2].dout, "post reset");

    // clear in SUBST together with in_valid
    mif.in_valid  = 1'b1;
    mif.in_data   = vecs[3].din;
    mif.out_ready = 1'b1;
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    @(negedge clk);
    clear        = 1'b1;
    mif.in_valid = 1'b1;
    mif.in_data  = vecs[0].din;
    @(posedge clk); #1;
    chk("clear in_ready", 128'(mif.in_ready), 128'd1);
    chk("clear busy", 128'(busy), 128'd0);
    chk("clear out_valid", 128'(mif.out_valid), 128'd0);
    @(negedge clk);
    clear        = 1'b0;
    mif.in_valid = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (mif.out_valid !== 1'b0 || busy !== 1'b0) saw = 1'b1;
    end
    chk("clear no stray out_valid", 128'(saw), 128'd0);
    // clear in IDLE blocks acceptance of a simultaneous in_valid
    @(negedge clk);
    clear        = 1'b1;
    mif.in_valid = 1'b1;
    @(posedge clk); #1;
    chk("clear idle no accept", 128'(busy), 128'd0);
    @(negedge clk);
    clear        = 1'b0;
    mif.in_valid = 1'b0;
    run_job(vecs[3].din, vecs[3].dout, "post clear");

    // Other LANES values
    sweep_go = 1'b1;
    for (int t = 0; t < 3000 && sweep_done < 3; t++) @(posedge clk);
    chk("sweep completed", 128'(sweep_done), 128'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 16);
    inv_sub_bytes_seq_if sif ();
    logic s_clear;
    logic s_busy;

    inv_sub_bytes_seq #(.LANES(L)) dut_s (
      .clk   (clk),
      .n_rst (n_rst),
      .clear (s_clear),
      .busy  (s_busy),
      .bus   (sif.slave)
    );

    initial begin
      logic [127:0] din, exp;
      int lat;
      s_clear       = 1'b0;
      sif.in_valid  = 1'b0;
      sif.in_data   = '0;
      sif.out_ready = 1'b1;
      wait (sweep_go);
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        if (j == 0) din = 128'h0f0e0d0c0b0a09080706050403020100;
        else        din = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int b = 0; b < 16; b++) exp[8*b +: 8] = inv_ref[din[8*b +: 8]];
        sif.in_valid = 1'b1;
        sif.in_data  = din;
        @(posedge clk); #1;
        sif.in_valid = 1'b0;
        sif.in_data  = ~din;
        lat = 0;
        while (sif.out_valid !== 1'b1 && lat < 40) begin
          @(posedge clk); #1;
          lat++;
        end
        chk($sformatf("sweep L%0d job%0d latency", L, j), 128'(lat), 128'(16 / L));
        chk($sformatf("sweep L%0d job%0d out_data", L, j), sif.out_data, exp);
        @(posedge clk); #1;
        chk($sformatf("sweep L%0d job%0d idle", L, j), 128'(s_busy), 128'd0);
        @(negedge clk);
      end
      sweep_done++;
    end
  end
endmodule

// File: doc/inv_sub_bytes_seq.md
INV_SUB_BYTES_SEQ -- requirements
Module: inv_sub_bytes_seq

Interface
REQ-001 Parameter: LANES, default 4, number of inverse-S-box byte lookups performed per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 n_rst  input  1  asynchronous, active-low reset.
REQ-004 clear  input  1  synchronous abort; returns block to IDLE.
REQ-005 in_valid  input  1  upstream presents a 128-bit state on in_data.
REQ-006 in_data  input  128  AES state; byte i = bits [8i+7:8i], i = 0..15.
REQ-007 in_ready  output  1  block can accept a new state.
REQ-008 out_valid  output  1  out_data holds a completed InvSubBytes result.
REQ-009 out_ready  input  1  downstream accepts out_data.
REQ-010 out_data  output  128  result state, same byte ordering as in_data.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The block SHALL hold a 128-bit working register and instantiate exactly LANES copies of the team's AES inverse S-box lookup, shared across all 16 bytes by time-multiplexing.
REQ-013 FSM states SHALL be IDLE, SUBST, DONE; chunk counter cnt width = clog2(16/LANES), minimum 1 bit.
REQ-014 IDLE: in_ready=1; on in_valid=1 at a clock edge the block SHALL load in_data into the working register, set cnt=0, go to SUBST.
REQ-015 SUBST: in_ready=0; each edge SHALL replace bytes cnt*LANES .. cnt*LANES+LANES-1 with their inverse-S-box values, other bytes unchanged, then increment cnt.
REQ-016 On the edge processing the final chunk (cnt = 16/LANES-1) the FSM SHALL go to DONE and cnt SHALL wrap to 0.
REQ-017 Latency: out_valid SHALL rise exactly 16/LANES edges after the accepting edge (4 for LANES=4, 1 for LANES=16).
REQ-018 DONE: out_valid=1, out_data = working register, held stable until out_ready=1 at an edge, then FSM SHALL go to IDLE.
REQ-019 in_ready SHALL be 0 in DONE; no new state is accepted in the same edge as the output handshake (minimum 1 idle cycle between jobs).
REQ-020 out_data SHALL equal the working register in all states; only its value while out_valid=1 is defined to the consumer.
REQ-021 in_valid in SUBST or DONE SHALL be ignored; in_data changes after acceptance SHALL not affect the result.
REQ-022 clear=1 SHALL force IDLE, cnt=0, out_valid=0 at the next edge from any state, overriding in_valid and out_ready; working register retains its value.
REQ-023 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-024 n_rst=0 SHALL immediately, without a clock edge, force IDLE, cnt=0, working register=0, giving in_ready=1, out_valid=0, busy=0, out_data=0.
REQ-025 Reset asserted mid-SUBST or in DONE SHALL discard the job; no out_valid SHALL appear after release until a new acceptance.
REQ-026 After n_rst deassertion the block SHALL accept in_valid on the first rising edge.

Verification
REQ-027 LANES=4, in_data all bytes 0x63, out_ready=1 -> out_valid rises 4 edges after acceptance, out_data all 0x00, in_ready returns 1 the following cycle.
REQ-028 LANES=4, byte0=0x00, byte1=0x7c, byte2=0x16, byte3=0x52, bytes 4..15=0x63 -> out bytes 0x52, 0x01, 0xff, 0x48, rest 0x00.
REQ-029 out_ready held 0 for 10 cycles in DONE -> out_valid and out_data stable throughout, in_in_valid pulses ignored, release on first out_ready=1 edge.
REQ-030 n_rst asserted asynchronously 2 edges into SUBST -> out_valid=0, in_ready=1 immediately, out_data=0; next job completes correctly.
REQ-031 clear=1 in SUBST together with in_valid=1 -> IDLE next edge, no out_valid, no acceptance that edge; subsequent job correct.
REQ-032 Sweep LANES in {1,2,16} with random states -> latency 16/LANES edges, every byte matches the AES inverse S-box table.
